// File: rtl/irq_pkg.sv
// Shared definitions for the interrupt request bank and the priority resolver.
package irq_pkg;
    localparam int   MAX_IRQ    = 32;
    localparam logic TRIG_EDGE  = 1'b0;
    localparam logic TRIG_LEVEL = 1'b1;

    // Index width for a channel count; a single-bit index is the floor.
    function automatic int idx_w(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction
endpackage

// File: rtl/irq_priority_resolver.sv
// Rotating-priority find-first: the search starts at base and wraps modulo NUM_IRQ.
module irq_priority_resolver
    import irq_pkg::*;
#(
    parameter  int NUM_IRQ = 8,
    localparam int IDX_W   = idx_w(NUM_IRQ)
) (
    input  logic [NUM_IRQ-1:0] req,
    input  logic [IDX_W-1:0]   base,
    output logic               valid,
    output logic [IDX_W-1:0]   index
);
    logic [NUM_IRQ-1:0] rotated;
    int                 eff_base;
    int                 first;
    int                 winner;

    always_comb begin
        eff_base = (int'(base) >= NUM_IRQ) ? 0 : int'(base);
        rotated  = NUM_IRQ'({req, req} >> eff_base);
        valid    = |rotated;
        first    = 0;
        // Descending scan so the lowest rotated position is the one left standing.
        for (int j = NUM_IRQ - 1; j >= 0; j--) begin
            if (rotated[j]) first = j;
        end
        winner = eff_base + first;
        if (winner >= NUM_IRQ) winner = winner - NUM_IRQ;
        index = valid ? IDX_W'(winner) : '0;
    end
endmodule

// File: rtl/interrupt_request_bank.sv
// Interrupt request register: synchronises request pins, captures them per channel in
// edge or level mode, clears on acknowledge and presents the winning unmasked request.
module interrupt_request_bank
    import irq_pkg::*;
#(
    parameter  int NUM_IRQ     = 8,
    parameter  int SYNC_STAGES = 2,
    localparam int IDX_W       = idx_w(NUM_IRQ)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_IRQ-1:0] Interrupt_Request_Pins,
    input  logic [NUM_IRQ-1:0] Trigger_Mode,
    input  logic [NUM_IRQ-1:0] Interrupt_Mask,
    input  logic [IDX_W-1:0]   Priority_Base,
    input  logic               Clear_Valid,
    input  logic [IDX_W-1:0]   Clear_Index,
    input  logic               Clear_All,
    output logic [NUM_IRQ-1:0] Interrupt_Request_Reg,
    output logic               Pending_Valid,
    output logic [IDX_W-1:0]   Pending_Index
);
    logic [NUM_IRQ-1:0] sync_pin;
    logic [NUM_IRQ-1:0] prev_pin;
    logic [NUM_IRQ-1:0] rise;
    logic [NUM_IRQ-1:0] irr_next;

    for (genvar i = 0; i < NUM_IRQ; i++) begin : g_sync
        logic [SYNC_STAGES-1:0] chain;
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) chain <= '0;
            else        chain <= {chain[SYNC_STAGES-2:0], Interrupt_Request_Pins[i]};
        end
        assign sync_pin[i] = chain[SYNC_STAGES-1];
    end

    assign rise = sync_pin & ~prev_pin;

    // An edge request outranks a same-cycle acknowledge so it is not lost; a level
    // channel honours the acknowledge for one cycle and recaptures from the pin next.
    always_comb begin
        irr_next = '0;
        for (int i = 0; i < NUM_IRQ; i++) begin
            logic hit;
            hit = Clear_Valid && (int'(Clear_Index) == i);
            if (Trigger_Mode[i] == TRIG_LEVEL)
                irr_next[i] = sync_pin[i] & ~hit;
            else
                irr_next[i] = rise[i] | (Interrupt_Request_Reg[i] & ~hit);
        end
        if (Clear_All) irr_next = '0;
    end

    // Edge history keeps tracking the pin through Clear_All and mode changes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_pin              <= '0;
            Interrupt_Request_Reg <= '0;
        end else begin
            prev_pin              <= sync_pin;
            Interrupt_Request_Reg <= irr_next;
        end
    end

    irq_priority_resolver #(.NUM_IRQ(NUM_IRQ)) u_resolver (
        .req   (Interrupt_Request_Reg & ~Interrupt_Mask),
        .base  (Priority_Base),
        .valid (Pending_Valid),
        .index (Pending_Index)
    );
endmodule

// File: tb/tb_interrupt_request_bank.sv
// Randomised and directed bench for interrupt_request_bank against a history-based model.
module tb_interrupt_request_bank;
    localparam int N  = 8;
    localparam int SS = 2;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [N-1:0] pins = '0;
    logic [N-1:0] trig = '0;
    logic [N-1:0] mask = '0;
    logic [2:0]   base = '0;
    logic         clr_v = 1'b0;
    logic [2:0]   clr_idx = '0;
    logic         clr_all = 1'b0;
    logic [N-1:0] irr;
    logic         pv;
    logic [2:0]   pidx;

    int vectors = 0;
    int errors  = 0;
    bit chk_on  = 1'b0;

    interrupt_request_bank #(.NUM_IRQ(N), .SYNC_STAGES(SS)) dut (
        .clk                   (clk),
        .rst_n                 (rst_n),
        .Interrupt_Request_Pins(pins),
        .Trigger_Mode          (trig),
        .Interrupt_Mask        (mask),
        .Priority_Base         (base),
        .Clear_Valid           (clr_v),
        .Clear_Index           (clr_idx),
        .Clear_All             (clr_all),
        .Interrupt_Request_Reg (irr),
        .Pending_Valid         (pv),
        .Pending_Index         (pidx)
    );

    initial forever #5 clk = ~clk;

    // Model: hist[k] is the pin value sampled k+1 edges ago; a pin reaches the
    // request logic SS edges after it is sampled.
    logic [N-1:0] m_irr;
    logic [N-1:0] hist [0:SS];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_irr = '0;
            for (int k = 0; k <= SS; k++) hist[k] = '0;
        end else begin
            logic [N-1:0] s, p, nx;
            s = hist[SS-1];
            p = hist[SS];
            for (int i = 0; i < N; i++) begin
                bit acked;
                acked = clr_v && (int'(clr_idx) == i);
                if (clr_all)      nx[i] = 1'b0;
                else if (trig[i]) nx[i] = s[i] && !acked;
                else              nx[i] = (s[i] && !p[i]) || (m_irr[i] && !acked);
            end
            m_irr = nx;
            for (int k = SS; k > 0; k--) hist[k] = hist[k-1];
            hist[0] = pins;
        end
    end

    function automatic void model_pend(input logic [N-1:0] r, input logic [N-1:0] m,
                                       input logic [2:0] b, output logic v, output logic [2:0] idx);
        v = 1'b0;
        idx = '0;
        for (int k = 0; k < N; k++) begin
            int c;
            c = (int'(b) + k) % N;
            if (!v && r[c] && !m[c]) begin
                v = 1'b1;
                idx = 3'(c);
            end
        end
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_on) begin
            logic       ev;
            logic [2:0] ei;
            model_pend(m_irr, mask, base, ev, ei);
            chk("irr_model", 32'(irr), 32'(m_irr));
            chk("pvalid_model", 32'(pv), 32'(ev));
            chk("pindex_model", 32'(pidx), 32'(ei));
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic pulse_clear_all();
        clr_all = 1'b1;
        tick();
        clr_all = 1'b0;
    endtask

    task automatic pulse_clear(input logic [2:0] idx);
        clr_v = 1'b1;
        clr_idx = idx;
        tick();
        clr_v = 1'b0;
    endtask

    initial begin
        // Reset with all pins high in level mode
        pins = 8'hFF;
        trig = 8'hFF;
        tick(2);
        chk_on = 1'b1;
        chk("rst_irr", 32'(irr), 32'h0);
        chk("rst_pvalid", 32'(pv), 32'h0);
        rst_n = 1'b1;
        tick(2);
        chk("rel_irr_e2", 32'(irr), 32'h0);
        tick();
        chk("rel_irr_e3", 32'(irr), 32'hFF);

        // Edge mode
        pins = '0;
        trig = '0;
        tick(4);
        pulse_clear_all();
        tick();
        chk("edge_idle", 32'(irr), 32'h0);
        pins = 8'b1000_0001;
        tick(2);
        chk("edge_e2", 32'(irr), 32'h0);
        tick();
        chk("edge_e3", 32'(irr), 32'h81);
        pins = '0;
        tick(4);
        chk("edge_hold", 32'(irr), 32'h81);
        pulse_clear(3'd0);
        chk("edge_clr0", 32'(irr), 32'h80);
        pulse_clear_all();
        chk("edge_clrall", 32'(irr), 32'h0);

        // Level mode
        trig = 8'hFF;
        pins = 8'b1100_1111;
        tick(3);
        chk("lvl_cf", 32'(irr), 32'hCF);
        pins = 8'b1101_0011;
        tick(2);
        chk("lvl_cf_hold", 32'(irr), 32'hCF);
        tick();
        chk("lvl_d3", 32'(irr), 32'hD3);
        pulse_clear(3'd7);
        chk("lvl_clr7", 32'(irr), 32'h53);
        tick();
        chk("lvl_recap7", 32'(irr), 32'hD3);

        // Asynchronous reset mid-cycle
        rst_n = 1'b0;
        #1;
        chk("async_rst_irr", 32'(irr), 32'h0);
        chk("async_rst_pv", 32'(pv), 32'h0);
        tick();
        rst_n = 1'b1;

        // Priority resolution on IRR = 0100_0100
        pins = 8'b0100_0100;
        tick(4);
        chk("prio_irr", 32'(irr), 32'h44);
        mask = '0; base = 3'd0; #1;
        chk("prio_b0", 32'(pidx), 32'd2);
        chk("prio_b0_v", 32'(pv), 32'd1);
        base = 3'd3; #1;
        chk("prio_b3", 32'(pidx), 32'd6);
        base = 3'd7; #1;
        chk("prio_b7", 32'(pidx), 32'd2);
        mask = 8'h04; base = 3'd0; #1;
        chk("prio_m04", 32'(pidx), 32'd6);
        mask = 8'h44; #1;
        chk("prio_m44_v", 32'(pv), 32'd0);
        chk("prio_m44_i", 32'(pidx), 32'd0);
        mask = '0;
        tick();

        // Collision: edge channel 3, rise meets acknowledge
        trig = '0;
        pins = '0;
        tick(4);
        pulse_clear_all();
        pins = 8'h08;
        tick(2);
        pulse_clear(3'd3);
        chk("coll_edge", 32'(irr[3]), 32'd1);

        // Collision: level channel 3
        pins = '0;
        trig = 8'h08;
        tick(4);
        pulse_clear_all();
        pins = 8'h08;
        tick(2);
        pulse_clear(3'd3);
        chk("coll_lvl", 32'(irr[3]), 32'd0);
        tick();
        chk("coll_lvl_next", 32'(irr[3]), 32'd1);

        // Mixed modes with a two-cycle pulse
        pins = '0;
        trig = 8'b0000_1111;
        tick(4);
        pulse_clear_all();
        pins = 8'hFF;
        tick(2);
        pins = '0;
        tick(5);
        chk("mixed_f0", 32'(irr), 32'hF0);
        pulse_clear(3'd1);
        chk("mixed_clr_empty", 32'(irr), 32'hF0);

        // Random traffic
        for (int c = 0; c < 600; c++) begin
            pins    = N'($urandom);
            mask    = N'($urandom);
            base    = 3'($urandom);
            clr_v   = ($urandom_range(0, 3) == 0);
            clr_idx = 3'($urandom);
            clr_all = ($urandom_range(0, 39) == 0);
            if ($urandom_range(0, 15) == 0) trig = N'($urandom);
            if ($urandom_range(0, 199) == 0) begin
                rst_n = 1'b0;
                #1;
                chk("rand_async_rst", 32'(irr), 32'h0);
                tick();
                rst_n = 1'b1;
            end else begin
                tick();
            end
        end
        clr_v = 1'b0;
        clr_all = 1'b0;
        tick(2);
        chk_on = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
